// File: rtl/sr_mc_unit_pkg.sv
// Shared types and helpers for the schoolRISCV multi-cycle execution unit.
// Op encoding: bit 1 selects divide vs multiply, bit 0 selects the high/remainder half.
package sr_mc_unit_pkg;

   typedef enum logic [1:0] {
      MC_OP_MUL   = 2'd0,
      MC_OP_MULHU = 2'd1,
      MC_OP_DIVU  = 2'd2,
      MC_OP_REMU  = 2'd3
   } mcOp_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_DONE
   } mcState_e;

   function automatic logic opIsDiv(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic opIsHigh(input logic [1:0] op);
      return op[0];
   endfunction

endpackage

// File: rtl/sr_mc_fifo.sv
// Synchronous request FIFO; pointers carry one extra wrap bit to tell full from empty.
module sr_mc_fifo
   import sr_mc_unit_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wrPtr;
   logic [AW:0]      rdPtr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             doPush;
   logic             doPop;

   assign empty  = (wrPtr == rdPtr);
   assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
   assign doPush = push && !full && !flush;
   assign doPop  = pop && !empty && !flush;
   assign rdata  = mem[rdPtr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else if (flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/sr_mc_unit.sv
// Multi-cycle MUL/MULHU/DIVU/REMU unit: in-order request queue feeding one iterative
// engine that shares a single 2W-bit shift register between shift-add and restoring divide.
module sr_mc_unit
   import sr_mc_unit_pkg::*;
#(
   parameter int W     = 32,
   parameter int DEPTH = 4,
   parameter int RDW   = 5
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic [1:0]     req_op,
   input  logic [RDW-1:0] req_rd,
   input  logic [W-1:0]   req_a,
   input  logic [W-1:0]   req_b,
   output logic           wb_valid,
   input  logic           wb_ready,
   output logic [RDW-1:0] wb_rd,
   output logic [W-1:0]   wb_data,
   output logic           busy
);

   localparam int QW = 2 + RDW + 2 * W;
   localparam int CW = $clog2(W);

   logic [QW-1:0]  qIn;
   logic [QW-1:0]  qOut;
   logic           qFull;
   logic           qEmpty;
   logic           qPush;
   logic           qPop;

   mcState_e       st;
   mcState_e       stNext;
   logic [1:0]     opR;
   logic [RDW-1:0] rdR;
   logic [W-1:0]   aR;
   logic [W-1:0]   bR;
   logic [2*W-1:0] prodR;
   logic [CW-1:0]  cnt;
   logic           wbValidR;
   logic [RDW-1:0] wbRdR;
   logic [W-1:0]   wbDataR;

   // Shift-add: conditionally add multiplicand into the upper half, then shift right with carry.
   function automatic logic [2*W-1:0] mulStep(input logic [2*W-1:0] p, input logic [W-1:0] a);
      logic [W:0] sum;
      sum = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, a} : {(W+1){1'b0}});
      return {sum, p[W-1:1]};
   endfunction

   // Restoring divide: remainder in the upper half, quotient bits shift in at the bottom.
   // A zero divisor always "succeeds", giving all-ones quotient and remainder = dividend.
   function automatic logic [2*W-1:0] divStep(input logic [2*W-1:0] p, input logic [W-1:0] b);
      logic [W:0] remSh;
      remSh = p[2*W-1:W-1];
      if (remSh >= {1'b0, b})
         return {W'(remSh - {1'b0, b}), p[W-2:0], 1'b1};
      else
         return {remSh[W-1:0], p[W-2:0], 1'b0};
   endfunction

   function automatic logic [W-1:0] resultSel(input logic high, input logic [2*W-1:0] p);
      return high ? p[2*W-1:W] : p[W-1:0];
   endfunction

   assign qIn       = {req_op, req_rd, req_a, req_b};
   assign qPush     = req_valid && !qFull;
   assign req_ready = !qFull;
   assign wb_valid  = wbValidR;
   assign wb_rd     = wbRdR;
   assign wb_data   = wbDataR;
   assign busy      = !qEmpty || (st != ST_IDLE) || wbValidR;

   sr_mc_fifo #(.WIDTH(QW), .DEPTH(DEPTH)) uFifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (qPush),
      .pop   (qPop),
      .wdata (qIn),
      .rdata (qOut),
      .full  (qFull),
      .empty (qEmpty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) st <= ST_IDLE;
      else     st <= stNext;
   end

   always_comb begin
      stNext = st;
      qPop   = 1'b0;
      case (st)
         ST_IDLE: if (!qEmpty) begin
            qPop   = 1'b1;
            stNext = ST_LOAD;
         end
         ST_LOAD: stNext = ST_RUN;
         ST_RUN:  if (cnt == '0) stNext = ST_DONE;
         ST_DONE: if (wbValidR && wb_ready) stNext = ST_IDLE;
         default: stNext = ST_IDLE;
      endcase
      if (flush) begin
         stNext = ST_IDLE;
         qPop   = 1'b0;
      end
   end

   // DONE spends its first cycle registering the selected half, so wb_rd/wb_data never glitch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opR      <= '0;
         rdR      <= '0;
         aR       <= '0;
         bR       <= '0;
         prodR    <= '0;
         cnt      <= '0;
         wbValidR <= 1'b0;
         wbRdR    <= '0;
         wbDataR  <= '0;
      end else if (flush) begin
         wbValidR <= 1'b0;
      end else begin
         case (st)
            ST_IDLE: if (qPop) {opR, rdR, aR, bR} <= qOut;
            ST_LOAD: begin
               prodR <= opIsDiv(opR) ? {{W{1'b0}}, aR} : {{W{1'b0}}, bR};
               cnt   <= CW'(W - 1);
            end
            ST_RUN: begin
               prodR <= opIsDiv(opR) ? divStep(prodR, bR) : mulStep(prodR, aR);
               cnt   <= cnt - 1'b1;
            end
            ST_DONE: begin
               if (!wbValidR) begin
                  wbValidR <= 1'b1;
                  wbRdR    <= rdR;
                  wbDataR  <= resultSel(opIsHigh(opR), prodR);
               end else if (wb_ready) begin
                  wbValidR <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
